// File: rtl/vga_timing_detect.sv
// vga_timing_detect: measures hs/vs/de stream geometry, regenerates x/y, tracks lock.
// Define VGA_TIMING_DETECT_EXPECT_EN to add EXP_* parameters and the mismatch output;
// lock then also requires the measured geometry to equal the expected geometry.
module vga_timing_detect #(
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1,
  parameter int          LOCK_FRAMES = 3,
  parameter logic [11:0] H_TIMEOUT   = 12'd4095
`ifdef VGA_TIMING_DETECT_EXPECT_EN
  ,
  parameter logic [11:0] EXP_H_TOTAL  = 12'd0,
  parameter logic [11:0] EXP_H_ACTIVE = 12'd0,
  parameter logic [10:0] EXP_V_TOTAL  = 11'd0,
  parameter logic [10:0] EXP_V_ACTIVE = 11'd0
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  output logic        de_out,
  output logic [11:0] x_out,
  output logic [10:0] y_out,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] h_sync,
  output logic [10:0] v_total,
  output logic [10:0] v_active,
  output logic        locked,
  output logic        lock_lost
`ifdef VGA_TIMING_DETECT_EXPECT_EN
  ,
  output logic        mismatch
`endif
);
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_FRAMES - 1);

  logic        hs1_q, hs1_d, hs2_q, hs2_d;
  logic        vs1_q, vs1_d, vs2_q, vs2_d;
  logic        de1_q, de1_d, de2_q, de2_d;
  logic [11:0] hc_q, hc_d, hsw_q, hsw_d, dew_q, dew_d, xc_q, xc_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d, lf_q, lf_d;
  logic [10:0] vc_q, vc_d, va_q, va_d, yc_q, yc_d;
  logic [11:0] x_out_q, x_out_d, h_total_q, h_total_d, h_active_q, h_active_d, h_sync_q, h_sync_d;
  logic [10:0] y_out_q, y_out_d, v_total_q, v_total_d, v_active_q, v_active_d;
  logic        frame_start_q, frame_start_d, lock_lost_q, lock_lost_d;
  state_t      state_q, state_d;
  logic [3:0]  mc_q, mc_d, mc_inc;
  logic [45:0] snap_q, snap_d, tuple;
  logic        hs_rise, hs_fall, vs_rise, de_fall, timeout, tup_eq, exp_ok;
  logic [10:0] vc_inc, va_inc;

  assign hs_rise = hs1_q & ~hs2_q;
  assign hs_fall = ~hs1_q & hs2_q;
  assign vs_rise = vs1_q & ~vs2_q;
  assign de_fall = ~de1_q & de2_q;
  assign timeout = (hc_q == H_TIMEOUT);
  assign vc_inc  = hs_rise ? vc_q + 11'd1 : vc_q;
  assign va_inc  = (hs_rise && lf_q) ? va_q + 11'd1 : va_q;
  assign tuple   = {h_total_d, h_active_d, v_total_d, v_active_d};
  assign tup_eq  = (tuple == snap_q);
  assign mc_inc  = (mc_q == 4'hf) ? mc_q : mc_q + 4'd1;

  // Input normalisation, line/sync/de measurement and frame-close captures
  always_comb begin
    hs1_d = hs ~^ HS_POL;
    vs1_d = vs ~^ VS_POL;
    de1_d = de;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    hc_d = hs_rise ? 12'd0 : ((hc_q == 12'hfff) ? hc_q : hc_q + 12'd1);
    h_total_d = (hs_rise && h_seen_q && !timeout) ? hc_q + 12'd1 : h_total_q;
    h_seen_d = hs_rise ? 1'b1 : (timeout ? 1'b0 : h_seen_q);
    hsw_d = hs1_q ? ((hsw_q == 12'hfff) ? hsw_q : hsw_q + 12'd1) : 12'd0;
    h_sync_d = hs_fall ? hsw_q : h_sync_q;
    dew_d = de1_q ? ((dew_q == 12'hfff) ? dew_q : dew_q + 12'd1) : 12'd0;
    h_active_d = de_fall ? dew_q : h_active_q;
    lf_d = hs_rise ? de1_q : (lf_q | de1_q);
    vc_d = vs_rise ? 11'd0 : vc_inc;
    va_d = vs_rise ? 11'd0 : va_inc;
    v_total_d = (vs_rise && v_seen_q) ? vc_inc : v_total_q;
    v_active_d = (vs_rise && v_seen_q) ? va_inc : v_active_q;
    v_seen_d = v_seen_q | vs_rise;
    frame_start_d = vs_rise;
  end

  // Coordinate counters; outputs follow de1 so they land two clocks after input de
  always_comb begin
    xc_d = de1_q ? xc_q + 12'd1 : 12'd0;
    yc_d = vs_rise ? 11'd0 : (de_fall ? yc_q + 11'd1 : yc_q);
    x_out_d = de1_q ? xc_q : x_out_q;
    y_out_d = de1_q ? yc_q : y_out_q;
  end

`ifdef VGA_TIMING_DETECT_EXPECT_EN
  logic mismatch_q, mismatch_d;
  assign exp_ok = (tuple == {EXP_H_TOTAL, EXP_H_ACTIVE, EXP_V_TOTAL, EXP_V_ACTIVE});
  assign mismatch = mismatch_q;

  // Expected-geometry flag, refreshed at each frame close
  always_comb begin
    mismatch_d = vs_rise ? !exp_ok : mismatch_q;
  end

  // Expected-geometry flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else mismatch_q <= mismatch_d;
  end
`else
  assign exp_ok = 1'b1;
`endif

  // Lock FSM next state, evaluated at frame close; line timeout overrides everything
  always_comb begin
    state_d = state_q;
    mc_d = mc_q;
    snap_d = snap_q;
    if (timeout) begin
      state_d = UNLOCKED;
    end else if (vs_rise) begin
      case (state_q)
        UNLOCKED: begin
          state_d = CHECK;
          snap_d = tuple;
          mc_d = 4'd0;
        end
        CHECK: begin
          if (tup_eq) begin
            mc_d = mc_inc;
            state_d = (mc_inc >= LOCK_LAST && exp_ok) ? LOCKED : CHECK;
          end else begin
            snap_d = tuple;
            mc_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!tup_eq) begin
            state_d = CHECK;
            snap_d = tuple;
            mc_d = 4'd0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
    lock_lost_d = (state_q == LOCKED) && (state_d != LOCKED);
  end

  // Lock FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      mc_q <= 4'd0;
      snap_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q <= mc_d;
      snap_q <= snap_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
      hc_q <= 12'd0;
      h_seen_q <= 1'b0;
      v_seen_q <= 1'b0;
      hsw_q <= 12'd0;
      dew_q <= 12'd0;
      lf_q <= 1'b0;
      vc_q <= 11'd0;
      va_q <= 11'd0;
      xc_q <= 12'd0;
      yc_q <= 11'd0;
      x_out_q <= 12'd0;
      y_out_q <= 11'd0;
      h_total_q <= 12'd0;
      h_active_q <= 12'd0;
      h_sync_q <= 12'd0;
      v_total_q <= 11'd0;
      v_active_q <= 11'd0;
      frame_start_q <= 1'b0;
    end else begin
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      de1_q <= de1_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      de2_q <= de2_d;
      hc_q <= hc_d;
      h_seen_q <= h_seen_d;
      v_seen_q <= v_seen_d;
      hsw_q <= hsw_d;
      dew_q <= dew_d;
      lf_q <= lf_d;
      vc_q <= vc_d;
      va_q <= va_d;
      xc_q <= xc_d;
      yc_q <= yc_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      h_total_q <= h_total_d;
      h_active_q <= h_active_d;
      h_sync_q <= h_sync_d;
      v_total_q <= v_total_d;
      v_active_q <= v_active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de_out = de2_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign frame_start = frame_start_q;
  assign h_total = h_total_q;
  assign h_active = h_active_q;
  assign h_sync = h_sync_q;
  assign v_total = v_total_q;
  assign v_active = v_active_q;
  assign locked = (state_q == LOCKED);
  assign lock_lost = lock_lost_q;
endmodule

// File: tb/tb_vga_timing_detect.sv
// tb_vga_timing_detect: phase table for geometry/lock plus x/y/de_out scoreboard
module tb_vga_timing_detect;
  logic clk = 1'b0;
  logic rst_n, hs, vs, de;
  logic de_out, frame_start, locked, lock_lost;
  logic [11:0] x_out, h_total, h_active, h_sync;
  logic [10:0] y_out, v_total, v_active;

  typedef struct { logic de; logic [11:0] x; logic [10:0] y; } sb_t;
  typedef struct { int hact, frames, h_total, h_active, v_total, v_active, locked, lost, fs, rise; } phase_t;

  sb_t sb[$];
  phase_t tbl[5];
  int n_vec = 0, n_err = 0, fs_cnt = 0, ll_cnt = 0, rise_fs = 0, base = 0;
  logic sb_en = 1'b0, locked_prev = 1'b0;
  logic [11:0] mx = '0;
  logic [10:0] my = '0;

  always #5 clk = ~clk;

  vga_timing_detect #(.LOCK_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
    .de_out(de_out), .x_out(x_out), .y_out(y_out), .frame_start(frame_start),
    .h_total(h_total), .h_active(h_active), .h_sync(h_sync),
    .v_total(v_total), .v_active(v_active), .locked(locked), .lock_lost(lock_lost)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    sb_t e;
    if (frame_start) fs_cnt++;
    if (lock_lost) ll_cnt++;
    if (locked && !locked_prev) begin
      check("lock_with_frame_start", frame_start, 1);
      rise_fs = fs_cnt;
    end
    if (!locked && locked_prev) check("lost_with_unlock", lock_lost, 1);
    locked_prev = locked;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("de_out", de_out, e.de);
      check("x_out", x_out, e.x);
      check("y_out", y_out, e.y);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic d, input int px, input int ln);
    @(posedge clk);
    #1;
    sample();
    hs = h;
    vs = v;
    de = d;
    if (sb_en) begin
      if (d) begin
        mx = 12'(px);
        my = 11'(ln);
      end
      sb.push_back('{d, mx, my});
    end
  endtask

  task automatic run_line(input int hact, input int ln, input int p0, input int p1);
    for (int p = p0; p < p1; p++)
      step(p >= hact + 2 && p < hact + 5, ln == 9 || ln == 10, ln < 8 && p < hact, p, ln);
  endtask

  task automatic run_frame(input int hact);
    for (int ln = 0; ln < 14; ln++) run_line(hact, ln, 0, hact + 10);
  endtask

  task automatic check_geom(input string tag, input int ht, input int ha, input int vt, input int va);
    check({tag, " h_total"}, h_total, ht);
    check({tag, " h_active"}, h_active, ha);
    check({tag, " h_sync"}, h_sync, 3);
    check({tag, " v_total"}, v_total, vt);
    check({tag, " v_active"}, v_active, va);
  endtask

  initial begin
    tbl[0] = '{16, 4, 26, 16, 14, 8, 1, 0, 4, 4};
    tbl[1] = '{16, 2, 26, 16, 14, 8, 1, 0, 6, 4};
    tbl[2] = '{18, 1, 28, 18, 14, 8, 0, 1, 7, 4};
    tbl[3] = '{16, 2, 26, 16, 14, 8, 0, 1, 9, 4};
    tbl[4] = '{16, 1, 26, 16, 14, 8, 1, 1, 10, 10};
    rst_n = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_zero", 32'(|{de_out, x_out, y_out, frame_start, h_total, h_active, h_sync,
                              v_total, v_active, locked, lock_lost}), 0);
    rst_n = 1'b1;
    sb_en = 1'b1;
    foreach (tbl[i]) begin
      for (int f = 0; f < tbl[i].frames; f++) run_frame(tbl[i].hact);
      check_geom($sformatf("phase%0d", i), tbl[i].h_total, tbl[i].h_active, tbl[i].v_total, tbl[i].v_active);
      check($sformatf("phase%0d locked", i), locked, tbl[i].locked);
      check($sformatf("phase%0d lock_lost count", i), ll_cnt, tbl[i].lost);
      check($sformatf("phase%0d frame_start count", i), fs_cnt, tbl[i].fs);
      check($sformatf("phase%0d lock rise frame", i), rise_fs, tbl[i].rise);
    end
    repeat (4100) step(1'b0, 1'b0, 1'b0, 0, 0);
    check("timeout locked", locked, 0);
    check("timeout lock_lost count", ll_cnt, 2);
    check("timeout h_total held", h_total, 26);
    repeat (3) run_frame(16);
    check_geom("after_timeout", 26, 16, 14, 8);
    check("after_timeout locked", locked, 1);
    check("after_timeout lock rise frame", rise_fs, 13);
    for (int ln = 0; ln < 3; ln++) run_line(16, ln, 0, 26);
    run_line(16, 3, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midline_reset_zero", 32'(|{de_out, x_out, y_out, frame_start, h_total, h_active, h_sync,
                                      v_total, v_active, locked, lock_lost}), 0);
    locked_prev = 1'b0;
    sb_en = 1'b0;
    sb.delete();
    base = fs_cnt;
    run_line(16, 3, 5, 8);
    rst_n = 1'b1;
    run_line(16, 3, 8, 26);
    for (int ln = 4; ln < 14; ln++) run_line(16, ln, 0, 26);
    check("post_reset unlocked", locked, 0);
    sb_en = 1'b1;
    repeat (3) run_frame(16);
    check_geom("post_reset", 26, 16, 14, 8);
    check("post_reset locked", locked, 1);
    check("post_reset lock rise frame", rise_fs, base + 4);
    check("post_reset lock_lost count", ll_cnt, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
